// File: rtl/multicycle_main_controller.sv
// Multi-cycle main control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_main_controller #(
    parameter logic [5:0] OPC_RTYPE = 6'b000000,
    parameter logic [5:0] OPC_LW    = 6'b100011,
    parameter logic [5:0] OPC_SW    = 6'b101011,
    parameter logic [5:0] OPC_ADDI  = 6'b001000,
    parameter logic [5:0] OPC_BNE   = 6'b000101,
    parameter logic [5:0] OPC_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        ADDI_EXEC = 4'd8,
        ADDI_WB   = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    // State and sticky illegal-opcode flag, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state: opcode dispatch in DECODE, mem_ready gates the wait states
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OPC_LW || opcode == OPC_SW) state_d = MEM_ADDR;
                else if (opcode == OPC_RTYPE)             state_d = R_EXEC;
                else if (opcode == OPC_ADDI)              state_d = ADDI_EXEC;
                else if (opcode == OPC_BNE)               state_d = BRANCH;
                else if (opcode == OPC_J)                 state_d = JUMP;
                else begin
                    state_d   = FETCH;
                    illegal_d = 1'b1;
                end
            end
            MEM_ADDR:  state_d = (opcode == OPC_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WRITE: if (mem_ready) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            ADDI_EXEC: state_d = ADDI_WB;
            default:   state_d = FETCH;
        endcase
    end

    // Control outputs from state; all forced low while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE:    alu_src_b = 2'b11;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB:   reg_write = 1'b1;
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state      = rst_n ? state_q : 4'd0;
    assign illegal_op = rst_n & illegal_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for multicycle_main_controller: per-instruction expected state traces
// built from instruction class and memory wait counts, checked every cycle.
module tb_multicycle_main_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;
    bit exp_ill = 1'b0;

    typedef struct {
        int st;
        bit rdy;
        bit ill;
    } step_t;

    step_t q[$];

    localparam logic [5:0] RT = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] BN = 6'b000101;
    localparam logic [5:0] JP = 6'b000010;

    multicycle_main_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_op, pc_source};

    // Expected control word for a named step of the instruction cycle
    function automatic logic [15:0] exp_out(int st, bit rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; sb = 2'b10; end
            9:  rw = 1;
            10: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(int st, bit rdy, bit ill = 1'b0);
        step_t e;
        e.st = st; e.rdy = rdy; e.ill = ill;
        q.push_back(e);
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    // Build the per-cycle trace of one instruction, then drive and check it
    task automatic run_instr(logic [5:0] op, int fw, int mw);
        for (int i = 0; i < fw; i++) push(0, 1'b0);
        push(0, 1'b1);
        case (op)
            LW: begin
                push(1, rnd()); push(2, rnd());
                for (int i = 0; i < mw; i++) push(3, 1'b0);
                push(3, 1'b1); push(4, rnd());
            end
            SW: begin
                push(1, rnd()); push(2, rnd());
                for (int i = 0; i < mw; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            RT: begin push(1, rnd()); push(6, rnd()); push(7, rnd()); end
            AI: begin push(1, rnd()); push(8, rnd()); push(9, rnd()); end
            BN: begin push(1, rnd()); push(10, rnd()); end
            JP: begin push(1, rnd()); push(11, rnd()); end
            default: push(1, rnd(), 1'b1);
        endcase
        drain(op);
    endtask

    task automatic drain(logic [5:0] op);
        step_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            opcode = op;
            mem_ready = e.rdy;
            @(negedge clk);
            chk("state", int'(state), e.st);
            chk("ctrl", int'(obs), int'(exp_out(e.st, e.rdy)));
            chk("illegal", int'(illegal_op), int'(exp_ill));
            if (e.ill) exp_ill = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_ctrl", int'(obs), 0);
        chk("rst_ill", int'(illegal_op), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        int k;
        ops[0] = RT; ops[1] = LW; ops[2] = SW; ops[3] = AI;
        ops[4] = BN; ops[5] = JP; ops[6] = 6'b111111;

        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
        reset_cycle();
        reset_cycle();
        rst_n = 1'b1;
        exp_ill = 1'b0;

        run_instr(RT, 0, 0);
        run_instr(LW, 0, 3);
        run_instr(BN, 0, 0);
        run_instr(JP, 0, 0);
        run_instr(SW, 1, 2);
        run_instr(6'b111111, 0, 0);
        run_instr(AI, 0, 0);
        run_instr(RT, 2, 0);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 6);
            op = ops[k];
            if (k == 6) begin
                do op = 6'($urandom);
                while (op == RT || op == LW || op == SW || op == AI ||
                       op == BN || op == JP);
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Abort a store while it waits on memory; reset must clear everything
        run_instr(6'b111110, 0, 0);
        push(0, 1'b1); push(1, 1'b1); push(2, 1'b1); push(5, 1'b0);
        drain(SW);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        exp_ill = 1'b0;
        reset_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(0, 1'b0);
        drain(SW);
        run_instr(SW, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
